// File: rtl/posit_extract_pipe.sv
// rtl/posit_extract_pipe.sv - three-stage elastic posit decoder (sign, flags, scale, fraction, magnitude, tag).
// Optional counters: define POSIT_EXTRACT_STATS_EN to add stat_words/stat_zero/stat_inf.
module posit_extract_pipe #(
   parameter int NBITS   = 32,
   parameter int ES      = 3,
   parameter int SCALE_W = 9,
   parameter int TAG_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NBITS-1:0]      in_data,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sign,
   output logic                  out_zero,
   output logic                  out_inf,
   output logic [SCALE_W-1:0]    out_scale,
   output logic [NBITS-ES-4:0]   out_frac,
   output logic [NBITS-2:0]      out_abs,
`ifdef POSIT_EXTRACT_STATS_EN
   output logic [31:0]           stat_words,
   output logic [15:0]           stat_zero,
   output logic [15:0]           stat_inf,
`endif
   output logic [TAG_W-1:0]      out_tag
);
   localparam int FW        = NBITS - ES - 3;
   localparam int MW        = $clog2(NBITS);
   localparam int KW        = MW + 1;
   localparam int MAX_SCALE = (NBITS - 1) * (1 << ES) + (1 << ES) - 1;

   if (MAX_SCALE > (1 << (SCALE_W - 1)) - 1 || NBITS < 8 || NBITS > 64 || ES > 4) begin : g_param_check
      $error("posit_extract_pipe: SCALE_W too small or NBITS/ES out of range");
   end

   logic v1_q, v2_q, v3_q;
   logic ld1, ld2, ld3;

   // A stage may load when it is empty or its successor is moving.
   assign ld3       = ~v3_q | out_ready;
   assign ld2       = ~v2_q | ld3;
   assign ld1       = ~v1_q | ld2;
   assign in_ready  = ld1;
   assign out_valid = v3_q;

   logic             s1_sign_d, s1_zero_d, s1_inf_d;
   logic [NBITS-1:0] s1_neg;
   logic [NBITS-2:0] s1_abs_d;
   logic             s1_sign_q, s1_zero_q, s1_inf_q;
   logic [NBITS-2:0] s1_abs_q;
   logic [TAG_W-1:0] s1_tag_q;

   always_comb begin
      s1_neg    = -in_data;
      s1_sign_d = in_data[NBITS-1];
      s1_zero_d = (in_data == '0);
      s1_inf_d  = in_data[NBITS-1] & (in_data[NBITS-2:0] == '0);
      s1_abs_d  = in_data[NBITS-1] ? s1_neg[NBITS-2:0] : in_data[NBITS-2:0];
   end

   logic          s2_r;
   logic          s2_run;
   logic [MW-1:0] s2_m_d, s2_rw_d;
   logic [KW-1:0] s2_k_d;

   always_comb begin
      s2_r   = s1_abs_q[NBITS-2];
      s2_run = 1'b1;
      s2_m_d = '0;
      for (int i = NBITS - 2; i >= 0; i--) begin
         if (s2_run && (s1_abs_q[i] == s2_r)) s2_m_d = s2_m_d + MW'(1);
         else                                  s2_run = 1'b0;
      end
      s2_k_d  = s2_r ? (KW'(s2_m_d) - KW'(1)) : -KW'(s2_m_d);
      s2_rw_d = (s2_m_d == MW'(NBITS - 1)) ? MW'(NBITS - 1) : s2_m_d + MW'(1);
   end

   logic             s2_sign_q, s2_zero_q, s2_inf_q;
   logic [NBITS-2:0] s2_abs_q;
   logic [TAG_W-1:0] s2_tag_q;
   logic [KW-1:0]    s2_k_q;
   logic [MW-1:0]    s2_rw_q;

   logic [NBITS-2:0]          s3_shifted;
   logic [SCALE_W-1:0]        s3_e;
   logic signed [SCALE_W-1:0] s3_k_ext;
   logic [SCALE_W-1:0]        s3_scale_d;
   logic [FW-1:0]             s3_frac_d;

   // After the regime (always >= 2 bits) the low two shifted bits are padding.
   always_comb begin
      s3_shifted = s2_abs_q << s2_rw_q;
      s3_e       = '0;
      for (int i = 0; i < ES; i++) s3_e = {s3_e[SCALE_W-2:0], s3_shifted[NBITS-2-i]};
      s3_k_ext   = SCALE_W'($signed(s2_k_q));
      s3_scale_d = SCALE_W'(s3_k_ext <<< ES) + s3_e;
      s3_frac_d  = FW'(s3_shifted >> 2);
      if (s2_zero_q | s2_inf_q) begin
         s3_scale_d = '0;
         s3_frac_d  = '0;
      end
   end

   logic               s3_sign_q, s3_zero_q, s3_inf_q;
   logic [SCALE_W-1:0] s3_scale_q;
   logic [FW-1:0]      s3_frac_q;
   logic [NBITS-2:0]   s3_abs_q;
   logic [TAG_W-1:0]   s3_tag_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
         s1_sign_q <= 1'b0; s1_zero_q <= 1'b0; s1_inf_q <= 1'b0;
         s1_abs_q  <= '0;   s1_tag_q  <= '0;
         s2_sign_q <= 1'b0; s2_zero_q <= 1'b0; s2_inf_q <= 1'b0;
         s2_abs_q  <= '0;   s2_tag_q  <= '0;   s2_k_q <= '0; s2_rw_q <= '0;
         s3_sign_q <= 1'b0; s3_zero_q <= 1'b0; s3_inf_q <= 1'b0;
         s3_scale_q <= '0;  s3_frac_q <= '0;   s3_abs_q <= '0; s3_tag_q <= '0;
      end else begin
         if (ld1) begin
            v1_q <= in_valid;
            if (in_valid) begin
               s1_sign_q <= s1_sign_d; s1_zero_q <= s1_zero_d; s1_inf_q <= s1_inf_d;
               s1_abs_q  <= s1_abs_d;  s1_tag_q  <= in_tag;
            end
         end
         if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
               s2_sign_q <= s1_sign_q; s2_zero_q <= s1_zero_q; s2_inf_q <= s1_inf_q;
               s2_abs_q  <= s1_abs_q;  s2_tag_q  <= s1_tag_q;
               s2_k_q    <= s2_k_d;    s2_rw_q   <= s2_rw_d;
            end
         end
         if (ld3) begin
            v3_q <= v2_q;
            if (v2_q) begin
               s3_sign_q  <= s2_sign_q;  s3_zero_q <= s2_zero_q; s3_inf_q <= s2_inf_q;
               s3_scale_q <= s3_scale_d; s3_frac_q <= s3_frac_d;
               s3_abs_q   <= s2_abs_q;   s3_tag_q  <= s2_tag_q;
            end
         end
      end
   end

   assign out_sign  = s3_sign_q;
   assign out_zero  = s3_zero_q;
   assign out_inf   = s3_inf_q;
   assign out_scale = s3_scale_q;
   assign out_frac  = s3_frac_q;
   assign out_abs   = s3_abs_q;
   assign out_tag   = s3_tag_q;

`ifdef POSIT_EXTRACT_STATS_EN
   logic [31:0] stat_words_q;
   logic [15:0] stat_zero_q, stat_inf_q;
   logic        out_fire;

   assign out_fire = v3_q & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_words_q <= '0;
         stat_zero_q  <= '0;
         stat_inf_q   <= '0;
      end else if (out_fire) begin
         stat_words_q <= stat_words_q + 32'd1;
         if (s3_zero_q && stat_zero_q != 16'hFFFF) stat_zero_q <= stat_zero_q + 16'd1;
         if (s3_inf_q && stat_inf_q != 16'hFFFF)   stat_inf_q  <= stat_inf_q + 16'd1;
      end
   end

   assign stat_words = stat_words_q;
   assign stat_zero  = stat_zero_q;
   assign stat_inf   = stat_inf_q;
`endif
endmodule

// File: tb/tb_posit_extract_pipe.sv
// tb/tb_posit_extract_pipe.sv - self-checking bench for posit_extract_pipe against an arithmetic posit model.
module tb_posit_extract_pipe;
   localparam int NBITS = 32;
   localparam int ES    = 3;
   localparam int FW    = NBITS - ES - 3;

   logic        clk, reset;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data;
   logic [7:0]  in_tag, out_tag;
   logic        out_sign, out_zero, out_inf;
   logic [8:0]  out_scale;
   logic [25:0] out_frac;
   logic [30:0] out_abs;
`ifdef POSIT_EXTRACT_STATS_EN
   logic [31:0] stat_words;
   logic [15:0] stat_zero, stat_inf;
`endif

   posit_extract_pipe #(.NBITS(32), .ES(3), .SCALE_W(9), .TAG_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_zero(out_zero), .out_inf(out_inf),
      .out_scale(out_scale), .out_frac(out_frac), .out_abs(out_abs),
`ifdef POSIT_EXTRACT_STATS_EN
      .stat_words(stat_words), .stat_zero(stat_zero), .stat_inf(stat_inf),
`endif
      .out_tag(out_tag)
   );

   typedef struct packed {
      logic        sign;
      logic        zero;
      logic        inf;
      logic [8:0]  scale;
      logic [25:0] frac;
      logic [30:0] abs;
      logic [7:0]  tag;
      int          lat;
   } rec_t;

   int n_vec, n_err;
   int stall_viol, ready_viol;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decode straight from the posit definition: count the regime run, then peel exponent and fraction.
   function automatic rec_t model(input logic [31:0] w, input logic [7:0] t);
      rec_t   m;
      longint a, rem, e, fval, fr;
      int     r, run, k, rw, remn, fn;
      m      = '0;
      m.sign = w[31];
      m.zero = (w == 32'h0);
      m.inf  = (w == 32'h8000_0000);
      m.tag  = t;
      a      = w[31] ? (64'sh1_0000_0000 - longint'(w)) : longint'(w);
      a      = a & 64'sh7FFF_FFFF;
      m.abs  = a[30:0];
      if (!m.zero && !m.inf) begin
         r   = int'(a[30]);
         run = 0;
         while (run < NBITS - 1 && int'(a[30 - run]) == r) run++;
         k    = (r == 1) ? run - 1 : -run;
         rw   = (run + 1 > NBITS - 1) ? NBITS - 1 : run + 1;
         remn = NBITS - 1 - rw;
         rem  = a & ((64'sd1 << remn) - 1);
         e    = (remn >= ES) ? (rem >> (remn - ES)) : (rem << (ES - remn));
         fn   = remn - ES;
         fval = (fn > 0) ? (rem & ((64'sd1 << fn) - 1)) : 64'sd0;
         fr   = (fn > 0) ? (fval << (FW - fn)) : 64'sd0;
         m.scale = 9'(k * (1 << ES) + int'(e));
         m.frac  = 26'(fr);
      end
      return m;
   endfunction

   task automatic sample(output rec_t s);
      s = '0;
      s.sign = out_sign; s.zero = out_zero; s.inf = out_inf;
      s.scale = out_scale; s.frac = out_frac; s.abs = out_abs; s.tag = out_tag;
   endtask

   // Streams words in as fast as accepted while randomly stalling the output; returns what came out.
   task automatic run_stream(input logic [31:0] words[$], input logic [7:0] tags[$],
                             input int ready_pct, output rec_t got[$]);
      int   acc_cyc[$];
      int   idx, cyc, inflight, start;
      bit   prev_stall;
      rec_t prev, cur;
      got = {};
      idx = 0; cyc = 0; inflight = 0; start = 0; prev_stall = 1'b0; prev = '0;
      while (got.size() < words.size() && cyc < 3000) begin
         @(negedge clk);
         in_valid  = (idx < words.size());
         in_data   = in_valid ? words[idx] : 32'h0;
         in_tag    = in_valid ? tags[idx] : 8'h0;
         out_ready = ($urandom_range(0, 99) < ready_pct);
         #1;
         if (in_ready !== !(inflight == 3 && !out_ready)) ready_viol++;
         sample(cur);
         if (out_valid) begin
            if (prev_stall) begin
               if (cur !== prev) stall_viol++;
            end else begin
               start = cyc;
            end
            if (out_ready) begin
               cur.lat = start - acc_cyc[got.size()];
               got.push_back(cur);
               cur.lat = 0;
               inflight--;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev       = cur;
         if (in_valid && in_ready) begin
            acc_cyc.push_back(cyc);
            idx++;
            inflight++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      n_vec++;
      if ({out_sign, out_zero, out_inf, out_scale, out_frac, out_abs, out_tag} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h exp 0", {out_sign, out_zero, out_inf, out_scale, out_frac, out_abs, out_tag});
      end
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_basic();
      rec_t got[$];
      run_stream('{32'h4000_0000}, '{8'h11}, 100, got);
      n_vec++;
      if (got.size() != 1) begin n_err++; $display("FAIL basic_count: got %0d exp 1", got.size()); end
      else begin
         n_vec++;
         if ({got[0].sign, got[0].zero, got[0].inf} !== 3'b000) begin
            n_err++; $display("FAIL basic_flags: got %b exp 000", {got[0].sign, got[0].zero, got[0].inf});
         end
         n_vec++;
         if (got[0].scale !== 9'd0 || got[0].frac !== 26'd0) begin
            n_err++; $display("FAIL basic_scale_frac: got %h/%h exp 0/0", got[0].scale, got[0].frac);
         end
         n_vec++;
         if (got[0].tag !== 8'h11) begin n_err++; $display("FAIL basic_tag: got %h exp 11", got[0].tag); end
         n_vec++;
         if (got[0].lat != 3) begin n_err++; $display("FAIL basic_latency: got %0d exp 3", got[0].lat); end
      end
   endtask

   task automatic test_back_to_back();
      rec_t got[$];
      run_stream('{32'h4800_0000, 32'hC000_0000, 32'h4080_0000}, '{8'h01, 8'h02, 8'h03}, 100, got);
      n_vec++;
      if (got.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d exp 3", got.size()); end
      else begin
         n_vec++;
         if (got[0].scale !== 9'd2 || got[0].frac !== 26'd0 || got[0].sign !== 1'b0) begin
            n_err++; $display("FAIL b2b_word0: got s=%b %h/%h exp 0 002/0", got[0].sign, got[0].scale, got[0].frac);
         end
         n_vec++;
         if (got[1].sign !== 1'b1 || got[1].scale !== 9'd0 || got[1].frac !== 26'd0) begin
            n_err++; $display("FAIL b2b_word1: got s=%b %h/%h exp 1 000/0", got[1].sign, got[1].scale, got[1].frac);
         end
         n_vec++;
         if (got[2].scale !== 9'd0 || got[2].frac !== 26'h080_0000) begin
            n_err++; $display("FAIL b2b_word2: got %h/%h exp 000/0800000", got[2].scale, got[2].frac);
         end
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (got[i].lat != 3 || got[i].tag !== 8'(i + 1)) begin
               n_err++; $display("FAIL b2b_lat_tag%0d: got %0d/%h exp 3/%h", i, got[i].lat, got[i].tag, 8'(i + 1));
            end
         end
      end
   endtask

   task automatic test_zero_nar();
      rec_t got[$];
      run_stream('{32'h0000_0000, 32'h8000_0000}, '{8'hA0, 8'hA1}, 100, got);
      n_vec++;
      if (got.size() != 2) begin n_err++; $display("FAIL zn_count: got %0d exp 2", got.size()); end
      else begin
         n_vec++;
         if ({got[0].sign, got[0].zero, got[0].inf, got[0].scale, got[0].frac, got[0].tag} !== {3'b010, 9'd0, 26'd0, 8'hA0}) begin
            n_err++; $display("FAIL zero_word: got %b %h %h %h", {got[0].sign, got[0].zero, got[0].inf}, got[0].scale, got[0].frac, got[0].tag);
         end
         n_vec++;
         if ({got[1].sign, got[1].zero, got[1].inf, got[1].scale, got[1].frac, got[1].tag} !== {3'b101, 9'd0, 26'd0, 8'hA1}) begin
            n_err++; $display("FAIL nar_word: got %b %h %h %h", {got[1].sign, got[1].zero, got[1].inf}, got[1].scale, got[1].frac, got[1].tag);
         end
      end
   endtask

   task automatic test_extremes();
      rec_t got[$];
      run_stream('{32'h0000_0001, 32'h7FFF_FFFF}, '{8'h5A, 8'hA5}, 100, got);
      n_vec++;
      if (got.size() != 2) begin n_err++; $display("FAIL ext_count: got %0d exp 2", got.size()); end
      else begin
         n_vec++;
         if (got[0].scale !== 9'h110 || got[0].frac !== 26'd0) begin
            n_err++; $display("FAIL ext_min: got %h/%h exp 110/0", got[0].scale, got[0].frac);
         end
         n_vec++;
         if (got[1].scale !== 9'h0F0 || got[1].frac !== 26'd0) begin
            n_err++; $display("FAIL ext_max: got %h/%h exp 0f0/0", got[1].scale, got[1].frac);
         end
      end
   endtask

   task automatic test_random_stall(input int count, input int ready_pct);
      logic [31:0] words[$];
      logic [7:0]  tags[$];
      rec_t        got[$];
      rec_t        exp;
      logic [31:0] w;
      stall_viol = 0;
      ready_viol = 0;
      for (int i = 0; i < count; i++) begin
         case ($urandom_range(0, 5))
            0:       w = 32'h0;
            1:       w = 32'h8000_0000;
            2:       w = $urandom >> $urandom_range(0, 31);
            3:       w = ~($urandom >> $urandom_range(0, 31));
            default: w = $urandom;
         endcase
         words.push_back(w);
         tags.push_back(8'($urandom));
      end
      run_stream(words, tags, ready_pct, got);
      n_vec++;
      if (got.size() != count) begin n_err++; $display("FAIL rnd_count: got %0d exp %0d", got.size(), count); end
      for (int i = 0; i < got.size(); i++) begin
         exp = model(words[i], tags[i]);
         got[i].lat = 0;
         n_vec++;
         if (got[i] !== exp) begin
            n_err++; $display("FAIL rnd_word%0d in=%h: got %h exp %h", i, words[i], got[i], exp);
         end
      end
      n_vec++;
      if (stall_viol != 0) begin n_err++; $display("FAIL stall_stability: got %0d changes exp 0", stall_viol); end
      n_vec++;
      if (ready_viol != 0) begin n_err++; $display("FAIL in_ready_rule: got %0d violations exp 0", ready_viol); end
   endtask

   task automatic test_reset_inflight();
      int seen;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 32'h4000_0000 + 32'(i); in_tag = 8'(i); out_ready = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL inflight_filled: got %b exp 1", out_valid); end
      reset = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL inflight_drop: got %b exp 0", out_valid); end
      @(negedge clk);
      reset     = 1'b0;
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_vec++;
      if (seen != 0) begin n_err++; $display("FAIL inflight_emitted: got %0d exp 0", seen); end
      out_ready = 1'b0;
   endtask

`ifdef POSIT_EXTRACT_STATS_EN
   task automatic test_stats();
      rec_t got[$];
      n_vec++;
      if ({stat_words, stat_zero, stat_inf} !== 64'h0) begin
         n_err++; $display("FAIL stats_reset: got %h/%h/%h exp 0/0/0", stat_words, stat_zero, stat_inf);
      end
      run_stream('{32'h0, 32'h4000_0000, 32'h4800_0000, 32'h7FFF_FFFF}, '{8'h1, 8'h2, 8'h3, 8'h4}, 60, got);
      n_vec++;
      if (stat_words !== 32'd4 || stat_zero !== 16'd1 || stat_inf !== 16'd0) begin
         n_err++; $display("FAIL stats_count: got %0d/%0d/%0d exp 4/1/0", stat_words, stat_zero, stat_inf);
      end
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_zero_nar();
      test_extremes();
      test_random_stall(10, 50);
      test_random_stall(200, 70);
      test_reset_inflight();
`ifdef POSIT_EXTRACT_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/posit_extract_pipe.md
Name: posit_extract_pipe

Overview:
- Parametrised, pipelined posit decoder. Takes a raw NBITS-wide posit with exponent size ES and produces sign, zero/NaR flags, signed scale and fraction.
- Three register stages with a valid/ready stream handshake and a pass-through tag.
- Sits between the posit operand buffers and the posit add/mul datapaths in the PairHMM cell pipeline.
- Replaces the fixed 32-bit/ES=3 combinational extractor.

Parameters:
- NBITS, 32, posit width (8..64).
- ES, 3, exponent field width (0..4).
- SCALE_W, 9, signed scale output width. Must hold ±((NBITS-1)·2^ES + 2^ES-1); elaboration error if too small.
- TAG_W, 8, width of the sideband tag carried alongside each operand.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word this cycle.
- in_data  in  NBITS  raw posit.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts.
- out_sign  out  1  posit sign bit.
- out_zero  out  1  input was 0.
- out_inf  out  1  input was NaR (1 followed by zeros).
- out_scale  out  SCALE_W  signed k·2^ES + e.
- out_frac  out  NBITS-ES-3  fraction bits below the hidden 1, MSB-aligned, zero-padded.
- out_abs  out  NBITS-1  magnitude (two's-complement absolute value, sign removed).
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset: all stage valids = 0, out_valid = 0. All data outputs = 0 (out_* registers cleared). in_ready = 1 once reset deasserts.
- Reset asserted mid-operation discards every in-flight word; no partial output.
- Transfer: in on in_valid & in_ready; out on out_valid & out_ready.
- Latency: 3 cycles from input transfer to out_valid, with no stalls. Throughput: 1 word/cycle.
- Elastic pipeline: stage n loads when it is empty or stage n+1 loads/drains. in_ready = ~s1_valid | s1_advance, where s1_advance is stage 1's load/drain condition. A combinational ready chain is permitted, not required.
- While out_valid & ~out_ready, all out_* signals are held stable and no word is dropped or duplicated.
- Stage 1:
  - sign = in_data[NBITS-1].
  - zero = in_data==0.
  - inf = sign & (in_data[NBITS-2:0]==0).
  - abs = sign ? -in_data : in_data, low NBITS-1 bits.
- Stage 2:
  - r = abs[NBITS-2].
  - m = run length of bits equal to r, starting at abs[NBITS-2] and scanning toward bit 0; max NBITS-1.
  - k = r ? m-1 : -m.
  - Regime width consumed = m+1, saturating at NBITS-1 when the run reaches bit 0.
- Stage 3:
  - Left-shift abs by the regime width.
  - e = next ES bits, zero-padded if truncated.
  - frac = following NBITS-ES-3 bits, zero-padded.
  - scale = sign-extended k·2^ES + e.
- When zero or inf is set: scale = 0, frac = 0. The flags still propagate with the tag.
- The tag travels unmodified with its word.

Optional Feature:
- Macro: POSIT_EXTRACT_STATS_EN.
- When defined, adds three outputs:
  - stat_words [31:0]: count of output transfers.
  - stat_zero [15:0]: output transfers with out_zero.
  - stat_inf [15:0]: output transfers with out_inf.
- Counters increment on output transfer only. All three reset to 0.
- stat_zero and stat_inf saturate at 0xFFFF. stat_words wraps.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then in_data=0x40000000, tag=0x11, out_ready=1 -> 3 cycles later: out_valid=1, sign=0, zero=0, inf=0, scale=0, frac=0, tag=0x11.
- Back-to-back inputs 0x48000000, 0xC0000000, 0x40800000 -> consecutive outputs:
  - scale=2, frac=0.
  - sign=1, scale=0, frac=0.
  - scale=0, frac=0x0800000.
- Inputs 0x00000000, 0x80000000 -> first output zero=1 only; second output inf=1, sign=1; scale=0 and frac=0 for both.
- Extremes 0x00000001 and 0x7FFFFFFF -> scale=-240 and scale=+240 (9-bit two's complement 0x110 / 0x0F0), frac=0.
- Stream of 10 words with out_ready toggled pseudo-randomly -> all 10 delivered in order, no loss or duplication, outputs stable during stall; in_ready low only while all 3 stages are full and stalled.
- Assert reset with 3 words in flight -> out_valid drops immediately, nothing emitted afterwards. With POSIT_EXTRACT_STATS_EN: counters read 0; after 4 transfers including 1 zero, stat_words=4, stat_zero=1.
